// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel data selector with manual and auto-scan modes.
//
// In manual mode the channel named by sel is registered onto m. In scan mode an
// internal pointer steps through every channel and spends DWELL enabled cycles
// on each one. All outputs are registered, so there is no combinational path
// from any input to any output.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   x        packed inputs; channel k at bits [k*WIDTH +: WIDTH]
//   sel      manual channel select (ignored in scan mode)
//   mode     0 = manual, 1 = scan
//   en       sample enable; 0 freezes data, channel and scan state
//   m        registered selected data
//   ch       channel index that m came from
//   m_valid  m/ch carry a valid sample this cycle
//   wrap     one-cycle pulse on the final sample of a full scan
module mux_scan_sel #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 4,
    localparam int unsigned SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] x,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          m,
    output logic [SELW-1:0]           ch,
    output logic                      m_valid,
    output logic                      wrap
);

    // The dwell counter needs at least one bit even when DWELL is 1.
    localparam int unsigned DCNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0]  LAST_CH = SELW'(CHANNELS - 1);
    localparam logic [DCNTW-1:0] LAST_DW = DCNTW'(DWELL - 1);

    logic [WIDTH-1:0] m_q, m_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [DCNTW-1:0] dcnt_q, dcnt_d;

    logic [SELW-1:0]  src_idx;
    logic [WIDTH-1:0] src_data;
    logic             src_hit;

    assign src_idx = mode ? ptr_q : sel;

    // Decode by comparison rather than a variable part-select so that an
    // out-of-range index (non power-of-two CHANNELS) yields zero and no hit.
    always_comb begin
        src_data = '0;
        src_hit  = 1'b0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (src_idx == SELW'(k)) begin
                src_data = x[k*WIDTH +: WIDTH];
                src_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        m_d     = m_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (en) begin
            if (!mode) begin
                // Manual: scan state is discarded so the next scan starts fresh.
                m_d     = src_data;
                ch_d    = sel;
                valid_d = src_hit;
                ptr_d   = '0;
                dcnt_d  = '0;
            end else begin
                m_d     = src_data;
                ch_d    = ptr_q;
                valid_d = 1'b1;
                if (dcnt_q == LAST_DW) begin
                    dcnt_d = '0;
                    if (ptr_q == LAST_CH) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + SELW'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q + DCNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            ptr_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            m_q     <= m_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign m       = m_q;
    assign ch      = ch_q;
    assign m_valid = valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Testbench for mux_scan_sel (WIDTH=8, CHANNELS=3, DWELL=2).
// A reference model counts enabled scan samples since the last restart and
// derives channel and wrap from that count arithmetically.
module tb_mux_scan_sel;

    localparam int W  = 8;
    localparam int CH = 3;
    localparam int DW = 2;
    localparam int SW = $clog2(CH);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] x;
    logic [SW-1:0]   sel;
    logic            mode;
    logic            en;
    logic [W-1:0]    m;
    logic [SW-1:0]   ch;
    logic            m_valid;
    logic            wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          scan_n = 0;
    logic [31:0] exp_m, exp_ch, exp_v, exp_wrap;

    mux_scan_sel #(
        .WIDTH   (W),
        .CHANNELS(CH),
        .DWELL   (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .sel    (sel),
        .mode   (mode),
        .en     (en),
        .m      (m),
        .ch     (ch),
        .m_valid(m_valid),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] chan_of(input logic [CH*W-1:0] xv, input int c);
        return 32'((xv >> (c * W)) & {W{1'b1}});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".m"}, 32'(m), exp_m);
        check({tag, ".ch"}, 32'(ch), exp_ch);
        check({tag, ".m_valid"}, 32'(m_valid), exp_v);
        check({tag, ".wrap"}, 32'(wrap), exp_wrap);
    endtask

    task automatic model_reset();
        scan_n   = 0;
        exp_m    = 0;
        exp_ch   = 0;
        exp_v    = 0;
        exp_wrap = 0;
    endtask

    // Apply one set of inputs across a rising edge, update the model, check.
    task automatic step(input string tag, input logic e, input logic md,
                        input logic [SW-1:0] s, input logic [CH*W-1:0] xv);
        en   = e;
        mode = md;
        sel  = s;
        x    = xv;
        @(posedge clk);
        if (!e) begin
            exp_v    = 0;
            exp_wrap = 0;
        end else if (!md) begin
            scan_n   = 0;
            exp_ch   = 32'(s);
            exp_wrap = 0;
            if (int'(s) < CH) begin
                exp_m = chan_of(xv, int'(s));
                exp_v = 1;
            end else begin
                exp_m = 0;
                exp_v = 0;
            end
        end else begin
            exp_ch   = 32'((scan_n / DW) % CH);
            exp_m    = chan_of(xv, int'(exp_ch));
            exp_v    = 1;
            exp_wrap = 32'((scan_n % (CH * DW)) == CH * DW - 1);
            scan_n++;
        end
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle, check outputs clear before the next edge, release.
    task automatic mid_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [CH*W-1:0] XFIX = {8'h33, 8'h22, 8'h11};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = '0;
        x     = XFIX;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 1'b0, 2'd1, XFIX);

        // Manual select of each channel, then out of range, then back in range
        for (int i = 0; i < CH; i++) step("manual", 1'b1, 1'b0, SW'(i), XFIX);
        step("sel_oor", 1'b1, 1'b0, 2'd3, XFIX);
        step("sel_back", 1'b1, 1'b0, 2'd2, XFIX);

        // Reset asserted with nonzero outputs, then idle until first enable
        mid_reset("rst_mid");
        step("rst_hold0", 1'b0, 1'b1, 2'd0, XFIX);
        step("rst_hold1", 1'b0, 1'b0, 2'd2, XFIX);

        // Full scan plus one: channels 0,0,1,1,2,2,0 with wrap on the 6th
        for (int i = 0; i < 7; i++) step("scan", 1'b1, 1'b1, 2'd3, XFIX);

        // Freeze after the third scan output, then resume
        step("restart", 1'b1, 1'b0, 2'd0, XFIX);
        for (int i = 0; i < 3; i++) step("frz_pre", 1'b1, 1'b1, 2'd0, XFIX);
        for (int i = 0; i < 3; i++) step("frz", 1'b0, 1'b1, 2'd0, XFIX);
        for (int i = 0; i < 6; i++) step("frz_post", 1'b1, 1'b1, 2'd0, XFIX);

        // Mode switch mid-scan and back
        step("ms_restart", 1'b1, 1'b0, 2'd0, XFIX);
        for (int i = 0; i < 5; i++) step("ms_scan", 1'b1, 1'b1, 2'd0, XFIX);
        step("ms_manual", 1'b1, 1'b0, 2'd1, XFIX);
        for (int i = 0; i < 4; i++) step("ms_rescan", 1'b1, 1'b1, 2'd0, XFIX);

        // Reset in the middle of a scan
        for (int i = 0; i < 3; i++) step("rs_scan", 1'b1, 1'b1, 2'd0, XFIX);
        mid_reset("rst_scan");
        for (int i = 0; i < 4; i++) step("rs_after", 1'b1, 1'b1, 2'd0, XFIX);

        // Randomized traffic, scan-heavy with occasional freezes and switches
        for (int i = 0; i < 400; i++) begin
            logic          e, md;
            logic [SW-1:0] s;
            logic [CH*W-1:0] xv;
            e  = ($urandom_range(0, 4) != 0);
            md = ($urandom_range(0, 5) != 0);
            s  = SW'($urandom_range(0, 3));
            xv = (CH*W)'($urandom());
            step("rand", e, md, s, xv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
